// File: rtl/seg_anim_pkg.sv
// Shared constants and the animation ROM for the seven-segment animator.
package seg_anim_pkg;

    localparam int NUM_ANIM = 8;
    localparam int ANIM_W   = 3;
    localparam int FRAME_W  = 4;
    localparam int SPD_W    = 3;

    localparam logic [SPD_W-1:0] SPD_MIN     = 3'd0;
    localparam logic [SPD_W-1:0] SPD_MAX     = 3'd7;
    localparam logic [SPD_W-1:0] SPEED_RESET = 3'd4;

    // Segment bits, bit0 = a.
    localparam logic [6:0] SEG_A    = 7'h01;
    localparam logic [6:0] SEG_B    = 7'h02;
    localparam logic [6:0] SEG_C    = 7'h04;
    localparam logic [6:0] SEG_D    = 7'h08;
    localparam logic [6:0] SEG_E    = 7'h10;
    localparam logic [6:0] SEG_F    = 7'h20;
    localparam logic [6:0] SEG_G    = 7'h40;
    localparam logic [6:0] SEG_ALL  = 7'h7F;
    localparam logic [6:0] SEG_NONE = 7'h00;

    typedef enum logic [ANIM_W-1:0] {
        ANIM_CW     = 3'd0,
        ANIM_CCW    = 3'd1,
        ANIM_FIG8   = 3'd2,
        ANIM_FILL   = 3'd3,
        ANIM_BOUNCE = 3'd4,
        ANIM_BLINK  = 3'd5,
        ANIM_SNAKE  = 3'd6,
        ANIM_COUNT  = 3'd7
    } anim_e;

    // Number of frames in each animation.
    function automatic logic [FRAME_W-1:0] anim_len(input logic [ANIM_W-1:0] anim);
        logic [FRAME_W-1:0] len;
        case (anim)
            ANIM_CW:     len = 4'd6;
            ANIM_CCW:    len = 4'd6;
            ANIM_FIG8:   len = 4'd8;
            ANIM_FILL:   len = 4'd8;
            ANIM_BOUNCE: len = 4'd4;
            ANIM_BLINK:  len = 4'd2;
            ANIM_SNAKE:  len = 4'd6;
            default:     len = 4'd10;
        endcase
        return len;
    endfunction

    // Segment pattern for a given animation and frame; unused frames are blank.
    function automatic logic [6:0] frame_pattern(input logic [ANIM_W-1:0]  anim,
                                                 input logic [FRAME_W-1:0] frame);
        logic [6:0] seg;
        seg = SEG_NONE;
        case (anim)
            ANIM_CW: case (frame)
                4'd0: seg = SEG_A;  4'd1: seg = SEG_B;  4'd2: seg = SEG_C;
                4'd3: seg = SEG_D;  4'd4: seg = SEG_E;  4'd5: seg = SEG_F;
                default: seg = SEG_NONE;
            endcase
            ANIM_CCW: case (frame)
                4'd0: seg = SEG_A;  4'd1: seg = SEG_F;  4'd2: seg = SEG_E;
                4'd3: seg = SEG_D;  4'd4: seg = SEG_C;  4'd5: seg = SEG_B;
                default: seg = SEG_NONE;
            endcase
            ANIM_FIG8: case (frame)
                4'd0: seg = SEG_A;  4'd1: seg = SEG_B;  4'd2: seg = SEG_G;
                4'd3: seg = SEG_E;  4'd4: seg = SEG_D;  4'd5: seg = SEG_C;
                4'd6: seg = SEG_G;  4'd7: seg = SEG_F;
                default: seg = SEG_NONE;
            endcase
            ANIM_FILL: case (frame)
                4'd0: seg = 7'h01;  4'd1: seg = 7'h03;  4'd2: seg = 7'h07;
                4'd3: seg = 7'h0F;  4'd4: seg = 7'h1F;  4'd5: seg = 7'h3F;
                4'd6: seg = SEG_ALL; 4'd7: seg = SEG_NONE;
                default: seg = SEG_NONE;
            endcase
            ANIM_BOUNCE: case (frame)
                4'd0: seg = SEG_A;  4'd1: seg = SEG_G;
                4'd2: seg = SEG_D;  4'd3: seg = SEG_G;
                default: seg = SEG_NONE;
            endcase
            ANIM_BLINK: case (frame)
                4'd0: seg = SEG_ALL;
                default: seg = SEG_NONE;
            endcase
            ANIM_SNAKE: case (frame)
                4'd0: seg = SEG_A | SEG_B;  4'd1: seg = SEG_B | SEG_C;
                4'd2: seg = SEG_C | SEG_D;  4'd3: seg = SEG_D | SEG_E;
                4'd4: seg = SEG_E | SEG_F;  4'd5: seg = SEG_F | SEG_A;
                default: seg = SEG_NONE;
            endcase
            default: case (frame)
                4'd0: seg = 7'h3F;  4'd1: seg = 7'h06;  4'd2: seg = 7'h5B;
                4'd3: seg = 7'h4F;  4'd4: seg = 7'h66;  4'd5: seg = 7'h6D;
                4'd6: seg = 7'h7D;  4'd7: seg = 7'h07;  4'd8: seg = 7'h7F;
                4'd9: seg = 7'h6F;
                default: seg = SEG_NONE;
            endcase
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button: 2-FF synchronizer, stability debounce, rising-edge pulse.
module button_debounce
    import seg_anim_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The down-counter runs only while the synchronized level disagrees with
    // the accepted level; any agreeing sample reloads it, so a glitch restarts
    // the whole stability window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
            stable_d = sync_q[1];
            cnt_d    = CNT_LOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Synchronizer, debounce state and edge-detect history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q       <= 2'b00;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= CNT_LOAD;
        end else begin
            sync_q       <= {sync_q[0], btn_i};
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    assign pulse_o = stable_q & ~stable_dly_q;

endmodule

// File: rtl/seven_segment_animator.sv
// Seven-segment animator tile: button-driven animation/speed select, step
// timer, frame sequencing and registered segment drive with dp heartbeat.
module seven_segment_animator
    import seg_anim_pkg::*;
#(
    parameter int TICK_BASE       = 10000,
    parameter int DEBOUNCE_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,     // active-high despite the name
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    localparam int TICK_W = $clog2(TICK_BASE * NUM_ANIM);

    // Step period minus one for a speed level; the counter runs down to zero.
    function automatic logic [TICK_W-1:0] tick_load(input logic [SPD_W-1:0] spd);
        return TICK_W'(TICK_BASE * (8 - int'(spd)) - 1);
    endfunction

    logic [3:0]         pulse;
    logic [ANIM_W-1:0]  anim_q, anim_d;
    logic [SPD_W-1:0]   spd_q, spd_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               dp_q, dp_d;
    logic [6:0]         seg_q;
    logic               anim_chg, spd_chg, step;

    wire unused_inputs = &{1'b0, ena, uio_in, ui_in[7:4]};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk_i  (clk),
            .rst_i  (rst_n),
            .btn_i  (ui_in[i]),
            .pulse_o(pulse[i])
        );
    end

    // Animation/speed selection, step timer and frame advance.
    always_comb begin
        anim_d  = anim_q;
        spd_d   = spd_q;
        frame_d = frame_q;
        tick_d  = tick_q;
        dp_d    = dp_q;
        step    = 1'b0;

        if (pulse[0] && !pulse[1]) begin
            anim_d = anim_q + 3'd1;
        end else if (pulse[1] && !pulse[0]) begin
            anim_d = anim_q - 3'd1;
        end

        if (pulse[2] && !pulse[3] && spd_q != SPD_MAX) begin
            spd_d = spd_q + 3'd1;
        end else if (pulse[3] && !pulse[2] && spd_q != SPD_MIN) begin
            spd_d = spd_q - 3'd1;
        end

        anim_chg = (anim_d != anim_q);
        spd_chg  = (spd_d != spd_q);

        // A selection change restarts the timer at the new rate and swallows
        // any step that would have fired in the same cycle.
        if (anim_chg || spd_chg) begin
            tick_d = tick_load(spd_d);
        end else if (tick_q == '0) begin
            step   = 1'b1;
            tick_d = tick_load(spd_q);
        end else begin
            tick_d = tick_q - 1'b1;
        end

        if (anim_chg) begin
            frame_d = '0;
        end else if (step) begin
            frame_d = (frame_q == anim_len(anim_q) - 4'd1) ? '0 : frame_q + 4'd1;
        end

        if (step) begin
            dp_d = ~dp_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            anim_q  <= ANIM_CW;
            spd_q   <= SPEED_RESET;
            frame_q <= '0;
            tick_q  <= tick_load(SPEED_RESET);
            dp_q    <= 1'b0;
        end else begin
            anim_q  <= anim_d;
            spd_q   <= spd_d;
            frame_q <= frame_d;
            tick_q  <= tick_d;
            dp_q    <= dp_d;
        end
    end

    // Registered segment lookup, one cycle behind the frame counter.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            seg_q <= SEG_A;
        end else begin
            seg_q <= frame_pattern(anim_q, frame_q);
        end
    end

    assign uo_out  = {dp_q, seg_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_seven_segment_animator.sv
module tb_seven_segment_animator;

    localparam int TB  = 20;   // scaled tick base
    localparam int DEB = 5;    // scaled debounce window
    localparam int SETTLE = DEB + 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic       ena = 1'b1;
    logic [7:0] uo_out, uio_out, uio_oe;

    seven_segment_animator #(
        .TICK_BASE      (TB),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena)
    );

    always #50 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [6:0] pats [8][10];
    int         lens [8];
    int         m_anim, m_spd;

    logic [6:0] cap_seg [3];
    int         cap_per [3];
    bit         cap_ok;

    typedef struct {
        logic [3:0] btn;
        int         exp_anim;
        int         exp_spd;
    } vec_t;
    vec_t vecs [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Record the segment value after each of the next three dp toggles and
    // the cycle distance to each toggle.
    task automatic capture();
        logic last;
        int   n;
        cap_ok = 1'b1;
        last   = uo_out[7];
        n      = 0;
        for (int k = 0; k < 3; k++) begin
            do begin
                @(negedge clk);
                n++;
            end while (uo_out[7] == last && n < 8 * TB + 40);
            if (uo_out[7] == last) begin
                checks++;
                cap_ok = 1'b0;
                $display("FAIL step_timeout: no dp toggle in %0d cycles, required within %0d", n, 8 * TB);
                return;
            end
            last       = uo_out[7];
            cap_per[k] = n;
            @(negedge clk);
            cap_seg[k] = uo_out[6:0];
            n          = 1;
        end
    endtask

    task automatic check_state(input string name, input int ea, input int es);
        bit found;
        capture();
        if (!cap_ok) return;
        check({name, " period_a"}, cap_per[1], TB * (8 - es));
        check({name, " period_b"}, cap_per[2], TB * (8 - es));
        found = 1'b0;
        for (int k = 0; k < lens[ea]; k++) begin
            if (pats[ea][k] == cap_seg[0] &&
                pats[ea][(k + 1) % lens[ea]] == cap_seg[1] &&
                pats[ea][(k + 2) % lens[ea]] == cap_seg[2])
                found = 1'b1;
        end
        checks++;
        if (found) passes++;
        else $display("FAIL %s frames: got %h,%h,%h, required 3 consecutive frames of anim %0d",
                      name, cap_seg[0], cap_seg[1], cap_seg[2], ea);
    endtask

    // Press a button mask, check first frame if the animation changes,
    // release and then check animation and speed through the step stream.
    task automatic press_op(input logic [3:0] mask, input int hold,
                            input int ea, input int es, input string name);
        int old_anim;
        old_anim = m_anim;
        ui_in = {4'h0, mask};
        cyc(SETTLE);
        if (ea != old_anim) check({name, " frame0"}, int'(uo_out[6:0]), int'(pats[ea][0]));
        if (hold > SETTLE) cyc(hold - SETTLE);
        ui_in = 8'h00;
        cyc(SETTLE);
        m_anim = ea;
        m_spd  = es;
        check_state(name, ea, es);
    endtask

    function automatic void model_apply(input logic [3:0] m);
        if (m[0] && !m[1]) m_anim = (m_anim + 1) % 8;
        if (m[1] && !m[0]) m_anim = (m_anim + 7) % 8;
        if (m[2] && !m[3] && m_spd < 7) m_spd++;
        if (m[3] && !m[2] && m_spd > 0) m_spd--;
    endfunction

    initial begin
        #(9_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rmask [6];
        int         na, ns;

        pats[0] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};
        pats[1] = '{7'h01, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h00, 7'h00, 7'h00, 7'h00};
        pats[2] = '{7'h01, 7'h02, 7'h40, 7'h10, 7'h08, 7'h04, 7'h40, 7'h20, 7'h00, 7'h00};
        pats[3] = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F, 7'h00, 7'h00, 7'h00};
        pats[4] = '{7'h01, 7'h40, 7'h08, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        pats[5] = '{7'h7F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        pats[6] = '{7'h03, 7'h06, 7'h0C, 7'h18, 7'h30, 7'h21, 7'h00, 7'h00, 7'h00, 7'h00};
        pats[7] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        lens    = '{6, 6, 8, 8, 4, 2, 6, 10};
        rmask   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100};

        // 10 x next wraps to anim 2, then prev/both/prev-wrap, speed saturation.
        for (int i = 1; i <= 10; i++) vecs.push_back('{4'b0001, i % 8, 4});
        vecs.push_back('{4'b0010, 1, 4});
        vecs.push_back('{4'b0011, 1, 4});
        vecs.push_back('{4'b0010, 0, 4});
        vecs.push_back('{4'b0010, 7, 4});
        vecs.push_back('{4'b1000, 7, 3});
        vecs.push_back('{4'b1000, 7, 2});
        vecs.push_back('{4'b1000, 7, 1});
        vecs.push_back('{4'b1000, 7, 0});
        vecs.push_back('{4'b1000, 7, 0});
        vecs.push_back('{4'b1000, 7, 0});
        for (int i = 1; i <= 5; i++) vecs.push_back('{4'b0100, 7, i});
        vecs.push_back('{4'b0100, 7, 6});
        vecs.push_back('{4'b0100, 7, 7});
        vecs.push_back('{4'b0100, 7, 7});
        vecs.push_back('{4'b1100, 7, 7});
        vecs.push_back('{4'b1000, 7, 6});

        // Reset state, then first steps from frame 0 at speed 4.
        cyc(3);
        check("reset uo_out", int'(uo_out), 8'h01);
        check("reset uio_out", int'(uio_out), 0);
        check("reset uio_oe", int'(uio_oe), 0);
        rst_n  = 1'b0;
        m_anim = 0;
        m_spd  = 4;
        capture();
        if (cap_ok) begin
            check("first step latency", cap_per[0], 4 * TB);
            check("step period", cap_per[1], 4 * TB);
            check("frame1", int'(cap_seg[0]), 8'h02);
            check("frame2", int'(cap_seg[1]), 8'h04);
            check("frame3", int'(cap_seg[2]), 8'h08);
        end

        // Directed vector table.
        foreach (vecs[i])
            press_op(vecs[i].btn, 2 * SETTLE, vecs[i].exp_anim, vecs[i].exp_spd,
                     $sformatf("vec%0d", i));

        // Short glitch on prev is rejected.
        ui_in = 8'h02;
        cyc(2);
        ui_in = 8'h00;
        cyc(SETTLE);
        check_state("glitch", m_anim, m_spd);

        // Long hold of slower gives one decrement only.
        press_op(4'b1000, 300, m_anim, m_spd - 1, "hold");

        // Randomized ops against the arithmetic model.
        for (int i = 0; i < 25; i++) begin
            logic [3:0] m;
            m  = rmask[$urandom_range(0, 5)];
            na = m_anim;
            ns = m_spd;
            model_apply(m);
            {na, ns} = {m_anim, m_spd};
            m_anim = (m[0] && !m[1]) ? (m_anim + 7) % 8 : (m[1] && !m[0]) ? (m_anim + 1) % 8 : m_anim;
            press_op(m, SETTLE + $urandom_range(0, 20), na, ns, $sformatf("rand%0d", i));
        end

        // Move to blink (never shows 01) and reset asynchronously mid-step.
        while (m_anim != 5) press_op(4'b0001, 2 * SETTLE, (m_anim + 1) % 8, m_spd, "to_blink");
        cyc(7);
        #20;
        rst_n = 1'b1;
        #1;
        check("async reset uo_out", int'(uo_out), 8'h01);
        cyc(2);
        rst_n  = 1'b0;
        m_anim = 0;
        m_spd  = 4;
        capture();
        if (cap_ok) begin
            check("post-reset latency", cap_per[0], 4 * TB);
            check("post-reset period", cap_per[1], 4 * TB);
            check("post-reset frame1", int'(cap_seg[0]), 8'h02);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_animator.md
Name: seven_segment_animator

Overview:
- Drives one seven-segment digit with one of 8 looping animations.
- Four push-buttons select the animation (next/previous) and the playback speed (faster/slower).
- Top-level tile block: all I/O is on the standard 8-bit ui/uo/uio pads.
- Runs from a 10 MHz system clock.

Parameters:
- TICK_BASE, 10000: clock cycles per speed unit (1 ms at 10 MHz).
- DEBOUNCE_CYCLES, 500: cycles an input must stay stable before it is accepted (50 us).
- NUM_ANIM, 8: number of animations; the index is 3 bits.
- SPEED_RESET, 4: speed level loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. Asynchronous and active-high despite its name: 1 = reset.
- ui_in  in  8  buttons, active-high.
  - [0] next animation.
  - [1] previous animation.
  - [2] faster.
  - [3] slower.
  - [7:4] unused.
- uo_out  out  8  segment drive, active-high.
  - [0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g.
  - [7]=dp heartbeat.
- uio_in  in  8  unused.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all uio pins are inputs).
- ena  in  1  ignored.

Behaviour:
- Button conditioning, per button:
  - 2-FF synchronizer, then debounce: the accepted level updates only after DEBOUNCE_CYCLES consecutive identical samples.
  - A rising edge of the accepted level produces a one-cycle pulse.
  - Holding a button yields exactly one pulse.
- Animation index anim (3 bits):
  - next pulse: +1, wraps 7→0.
  - prev pulse: -1, wraps 0→7.
  - next and prev in the same cycle: no change.
  - Any change sets frame to 0 and clears the tick counter.
- Speed level spd (0..7):
  - faster pulse: +1, saturates at 7.
  - slower pulse: -1, saturates at 0.
  - Both in the same cycle: no change.
  - Any change clears the tick counter; frame is kept.
- Tick counter:
  - Counts 0..(TICK_BASE*(8-spd))-1, then emits a one-cycle step and restarts at 0.
  - Step period is 1 ms at spd=7 and 8 ms at spd=0 with the default TICK_BASE.
- On step: frame advances; when it reaches the animation length it wraps to 0. dp toggles.
- Output timing: uo_out[6:0] is a registered lookup of (anim, frame), one cycle latency after frame updates.
- Animation frames (hex, bit0=a):
  - 0 clockwise spin, 6 frames: 01,02,04,08,10,20.
  - 1 counter-clockwise spin, 6 frames: 01,20,10,08,04,02.
  - 2 figure eight, 8 frames: 01,02,40,10,08,04,40,20.
  - 3 fill, 8 frames: 01,03,07,0F,1F,3F,7F,00.
  - 4 vertical bounce, 4 frames: 01,40,08,40.
  - 5 blink, 2 frames: 7F,00.
  - 6 snake pair, 6 frames: 03,06,0C,18,30,21.
  - 7 decimal count, 10 frames: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
- Reset (asynchronous):
  - anim=0, frame=0, spd=SPEED_RESET, tick counter=0.
  - Synchronizers and debouncers cleared.
  - uo_out=8'h01, uio_out=0, uio_oe=0.
  - Button activity during reset is discarded.
  - Reset mid-animation returns to these values immediately.

Decomposition:
- Package seg_anim_pkg holds:
  - segment bit constants SEG_A..SEG_G;
  - the frame-length table and the frame-pattern ROM function;
  - NUM_ANIM and speed limits.
- One sub-module, button_debounce (synchronizer + debounce + edge pulse), instantiated 4 times.
- Top level holds the anim/speed registers, tick counter, frame counter and output register.

Test Plan:
- Reset release with no buttons → uo_out=01. After 4 ms (spd 4) → 02, after 8 ms → 04. dp toggles each step.
- 10 presses on ui_in[0] (100 us high / 100 us low each) → anim=2 (wrapped). First frame 01 is shown after the final press; next step shows 02, then 40.
- 2 us glitch on ui_in[1] → no change. 100 us press of ui_in[1] from anim 0 → anim=7, output 3F.
- 6 presses on ui_in[3] from reset → spd=0, frame period measured 8 ms. 5 presses on ui_in[2] → spd=5, period 3 ms.
- ui_in[2] held for 10 ms → single increment only.
- ui_in[0] and ui_in[1] pressed on the same cycle → anim unchanged. Assert rst_n mid-animation → uo_out=01 asynchronously, and spd returns to 4.
